change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Parameters
REQ-001 The block SHALL have parameter EJECT_GAP, default 2, giving the idle cycles after each coin pulse; legal range is 1..15.

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to dispense change_in; sampled only in IDLE.
REQ-005 The block SHALL have port change_in, input, 8 bits: unsigned change amount from the vending controller.
REQ-006 The block SHALL have port eject_ready, input, 1 bit: the coin ejector can accept one coin.
REQ-007 The block SHALL have port coin_eject, output, 1 bit: one-cycle pulse per coin ejected.
REQ-008 The block SHALL have port coin_denom, output, 4 bits: one-hot selected coin, 4'b1000=10, 4'b0100=5, 4'b0010=2, 4'b0001=1, 4'b0000=none.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse when a job completes.
REQ-011 The block SHALL have port remaining, output, 8 bits: change still owed.
REQ-012 The block SHALL have ports cnt_10, cnt_5, cnt_2 and cnt_1, outputs, 5 bits each: coins of each denomination ejected in the current job.
REQ-013 The block SHALL have port total_out, output, 8 bits: sum of coin values ejected in the current job.

Function
REQ-014 The state machine SHALL have states IDLE, SELECT, EJECT, GAP and DONE, and all outputs SHALL be registered.
REQ-015 In IDLE with start=1 and change_in!=0, the block SHALL load remaining=change_in, clear all counters and total_out, and go to SELECT.
REQ-016 In IDLE with start=1 and change_in==0, the block SHALL clear the counters and go directly to DONE, ejecting no coins.
REQ-017 In SELECT, the block SHALL set coin_denom to the largest of 10/5/2/1 that is <= remaining (greedy), then go to EJECT.
REQ-018 EJECT SHALL hold while eject_ready=0, with coin_denom held stable and no timeout.
REQ-019 On an edge in EJECT with eject_ready=1, the block SHALL set coin_eject=1 for exactly one cycle, subtract the denomination from remaining, increment the matching cnt_x, add the denomination to total_out, and go to GAP.
REQ-020 GAP SHALL last exactly EJECT_GAP cycles and then go to DONE if remaining==0, otherwise to SELECT.
REQ-021 DONE SHALL assert done for one cycle, set coin_denom=0 and busy=0 on exit, and return to IDLE.
REQ-022 start SHALL be ignored in every state except IDLE, and change_in SHALL only be sampled on the accepting edge.
REQ-023 cnt_x, total_out and remaining SHALL hold their final values in IDLE until the next accepted start.
REQ-024 remaining+total_out SHALL equal the latched change_in at every cycle of a job, and the arithmetic SHALL never underflow.
REQ-025 A job with change_in=255 SHALL yield cnt_10=25, cnt_5=1, cnt_2=0 and cnt_1=0 (5-bit counters are sufficient).
REQ-026 Per-coin latency with eject_ready held high SHALL be 2+EJECT_GAP cycles (SELECT, EJECT, GAP).

Reset
REQ-027 With rst=1 on an edge, the block SHALL enter IDLE with coin_eject=0, coin_denom=0, busy=0, done=0, remaining=0, all cnt_x=0 and total_out=0.
REQ-028 Reset SHALL take priority over all other inputs, including start on the same edge.
REQ-029 Reset in any mid-job state SHALL abort the job with no further coin_eject or done pulses.

Verification
REQ-030 The bench SHALL cover: EJECT_GAP=2, eject_ready=1, start with change_in=18 -> coin_denom sequence 1000, 0100, 0010, 0001; coin_eject on cycles 3, 7, 11 and 15 after start; done on cycle 17; cnt_10=1, cnt_5=1, cnt_2=1, cnt_1=1; total_out=18; remaining=0.
REQ-031 The bench SHALL cover: start with change_in=0 -> done one cycle later, no coin_eject, all counters 0.
REQ-032 The bench SHALL cover: change_in=255 -> 26 coin_eject pulses, cnt_10=25, cnt_5=1, total_out=255.
REQ-033 The bench SHALL cover: change_in=7, eject_ready=0 for 10 cycles during the first EJECT -> coin_denom=0100 held, no pulse, and the first pulse arrives one cycle after ready rises; final cnt_5=1, cnt_2=1.
REQ-034 The bench SHALL cover: start re-pulsed with change_in=9 while busy during a change_in=12 job -> ignored; total_out=12.
REQ-035 The bench SHALL cover: rst asserted in GAP after the first coin of change_in=16 -> next cycle IDLE with all outputs 0, and no further pulses.

Source files
------------

// File: rtl/change_dispenser.sv
// Greedy coin dispenser: pays out an 8-bit change amount as 10/5/2/1 coins,
// one coin per ejector handshake, with a fixed idle gap after every coin.
module change_dispenser #(
   parameter int EJECT_GAP = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] change_in,
   input  logic       eject_ready,
   output logic       coin_eject,
   output logic [3:0] coin_denom,
   output logic       busy,
   output logic       done,
   output logic [7:0] remaining,
   output logic [4:0] cnt_10,
   output logic [4:0] cnt_5,
   output logic [4:0] cnt_2,
   output logic [4:0] cnt_1,
   output logic [7:0] total_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_EJECT,
      S_GAP,
      S_DONE
   } state_t;

   localparam logic [3:0] GAP_LAST = 4'(EJECT_GAP - 1);

   state_t     state_q;
   logic [3:0] gap_q;
   logic       coin_eject_q;
   logic [3:0] coin_denom_q;
   logic       busy_q;
   logic       done_q;
   logic [7:0] remaining_q;
   logic [4:0] cnt_10_q, cnt_5_q, cnt_2_q, cnt_1_q;
   logic [7:0] total_q;
   logic [7:0] coin_val_d;

   // Largest coin not exceeding the amount still owed.
   function automatic logic [3:0] pick_coin(input logic [7:0] amt);
      if (amt >= 8'd10)     return 4'b1000;
      else if (amt >= 8'd5) return 4'b0100;
      else if (amt >= 8'd2) return 4'b0010;
      else if (amt >= 8'd1) return 4'b0001;
      else                  return 4'b0000;
   endfunction

   function automatic logic [7:0] coin_value(input logic [3:0] oh);
      case (oh)
         4'b1000: return 8'd10;
         4'b0100: return 8'd5;
         4'b0010: return 8'd2;
         4'b0001: return 8'd1;
         default: return 8'd0;
      endcase
   endfunction

   assign coin_val_d = coin_value(coin_denom_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         gap_q        <= '0;
         coin_eject_q <= 1'b0;
         coin_denom_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         remaining_q  <= '0;
         cnt_10_q     <= '0;
         cnt_5_q      <= '0;
         cnt_2_q      <= '0;
         cnt_1_q      <= '0;
         total_q      <= '0;
      end else begin
         coin_eject_q <= 1'b0;
         done_q       <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  remaining_q <= change_in;
                  cnt_10_q    <= '0;
                  cnt_5_q     <= '0;
                  cnt_2_q     <= '0;
                  cnt_1_q     <= '0;
                  total_q     <= '0;
                  busy_q      <= 1'b1;
                  if (change_in != 8'd0) begin
                     state_q <= S_SELECT;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_SELECT: begin
               coin_denom_q <= pick_coin(remaining_q);
               state_q      <= S_EJECT;
            end
            S_EJECT: begin
               if (eject_ready) begin
                  coin_eject_q <= 1'b1;
                  remaining_q  <= remaining_q - coin_val_d;
                  total_q      <= total_q + coin_val_d;
                  case (coin_denom_q)
                     4'b1000: cnt_10_q <= cnt_10_q + 5'd1;
                     4'b0100: cnt_5_q  <= cnt_5_q + 5'd1;
                     4'b0010: cnt_2_q  <= cnt_2_q + 5'd1;
                     default: cnt_1_q  <= cnt_1_q + 5'd1;
                  endcase
                  gap_q   <= GAP_LAST;
                  state_q <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_q == 4'd0) begin
                  if (remaining_q == 8'd0) begin
                     state_q      <= S_DONE;
                     done_q       <= 1'b1;
                     coin_denom_q <= '0;
                  end else begin
                     state_q <= S_SELECT;
                  end
               end else begin
                  gap_q <= gap_q - 4'd1;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign coin_eject = coin_eject_q;
   assign coin_denom = coin_denom_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign remaining  = remaining_q;
   assign cnt_10     = cnt_10_q;
   assign cnt_5      = cnt_5_q;
   assign cnt_2      = cnt_2_q;
   assign cnt_1      = cnt_1_q;
   assign total_out  = total_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus queues expected coins and job
// totals from an arithmetic change model; a negedge monitor pops and compares.
module tb_change_dispenser;
   localparam int EJECT_GAP = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] change_in = '0;
   logic       eject_ready = 1'b0;
   logic       coin_eject;
   logic [3:0] coin_denom;
   logic       busy, done;
   logic [7:0] remaining, total_out;
   logic [4:0] cnt_10, cnt_5, cnt_2, cnt_1;

   change_dispenser #(.EJECT_GAP(EJECT_GAP)) dut (
      .clk(clk), .rst(rst), .start(start), .change_in(change_in),
      .eject_ready(eject_ready), .coin_eject(coin_eject), .coin_denom(coin_denom),
      .busy(busy), .done(done), .remaining(remaining),
      .cnt_10(cnt_10), .cnt_5(cnt_5), .cnt_2(cnt_2), .cnt_1(cnt_1),
      .total_out(total_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      int c10;
      int c5;
      int c2;
      int c1;
      int total;
   } res_t;

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         s0 = 0;
   int         job_amt = 0;
   int         done_cnt = 0;
   int         done_cyc = 0;
   bit         rnd_ready = 1'b0;
   logic [3:0] coin_q[$];
   res_t       res_q[$];
   int         pulse_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Change model: plain division by coin values, largest coin first.
   task automatic expect_job(input int amt);
      res_t r;
      int   rest;
      r.c10 = amt / 10;  rest = amt % 10;
      r.c5  = rest / 5;  rest = rest % 5;
      r.c2  = rest / 2;
      r.c1  = rest % 2;
      r.total = amt;
      for (int i = 0; i < r.c10; i++) coin_q.push_back(4'b1000);
      for (int i = 0; i < r.c5; i++)  coin_q.push_back(4'b0100);
      for (int i = 0; i < r.c2; i++)  coin_q.push_back(4'b0010);
      for (int i = 0; i < r.c1; i++)  coin_q.push_back(4'b0001);
      res_q.push_back(r);
   endtask

   initial begin
      logic [3:0] exp_d;
      res_t       r;
      forever begin
         @(negedge clk);
         if (coin_eject) begin
            pulse_cyc.push_back(cyc);
            if (coin_q.size() == 0) chk("unexpected_coin", 1, 0);
            else begin
               exp_d = coin_q.pop_front();
               chk("coin_denom", int'(coin_denom), int'(exp_d));
            end
         end
         if (busy) chk("conservation", int'(remaining) + int'(total_out), job_amt);
         if (done) begin
            done_cyc = cyc;
            done_cnt++;
            if (res_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               r = res_q.pop_front();
               chk("cnt_10", int'(cnt_10), r.c10);
               chk("cnt_5", int'(cnt_5), r.c5);
               chk("cnt_2", int'(cnt_2), r.c2);
               chk("cnt_1", int'(cnt_1), r.c1);
               chk("total_out", int'(total_out), r.total);
               chk("done_remaining", int'(remaining), 0);
               chk("done_denom", int'(coin_denom), 0);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rnd_ready) eject_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_eject"}, int'(coin_eject), 0);
      chk({tag, "_denom"}, int'(coin_denom), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_remaining"}, int'(remaining), 0);
      chk({tag, "_cnts"}, int'(cnt_10) + int'(cnt_5) + int'(cnt_2) + int'(cnt_1), 0);
      chk({tag, "_total"}, int'(total_out), 0);
   endtask

   task automatic do_start(input int amt);
      @(negedge clk);
      s0 = cyc;
      job_amt = amt;
      expect_job(amt);
      pulse_cyc.delete();
      change_in = 8'(amt);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      change_in = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_done(input int d0);
      bit seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(posedge clk);
         if (done_cnt > d0) seen = 1'b1;
      end
      if (!seen) chk("done_timeout", 0, 1);
   endtask

   task automatic run_job(input int amt);
      int d0;
      d0 = done_cnt;
      do_start(amt);
      wait_done(d0);
      repeat (2) @(negedge clk);
      chk("idle_busy", int'(busy), 0);
      chk("held_total", int'(total_out), amt);
      chk("held_remaining", int'(remaining), 0);
   endtask

   initial begin
      int d0;
      int exp_pulse[4] = '{3, 7, 11, 15};

      // Reset state, then reset winning over a simultaneous start.
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      start = 1'b1;
      change_in = 8'd50;
      @(negedge clk);
      chk("rst_prio_busy", int'(busy), 0);
      chk("rst_prio_remaining", int'(remaining), 0);
      start = 1'b0;
      rst = 1'b0;
      eject_ready = 1'b1;

      // 18 with ready high: exact pulse and done timing.
      run_job(18);
      chk("t18_pulses", pulse_cyc.size(), 4);
      for (int i = 0; i < 4 && i < pulse_cyc.size(); i++)
         chk("t18_pulse_cycle", pulse_cyc[i] - s0, exp_pulse[i]);
      chk("t18_done_cycle", done_cyc - s0, 17);
      chk("t18_held_cnt10", int'(cnt_10), 1);
      chk("t18_held_cnt1", int'(cnt_1), 1);

      // Zero change.
      run_job(0);
      chk("t0_done_cycle", done_cyc - s0, 1);
      chk("t0_pulses", pulse_cyc.size(), 0);
      chk("t0_cnts", int'(cnt_10) + int'(cnt_5) + int'(cnt_2) + int'(cnt_1), 0);

      // Maximum amount.
      run_job(255);
      chk("t255_pulses", pulse_cyc.size(), 26);
      chk("t255_cnt10", int'(cnt_10), 25);
      chk("t255_cnt5", int'(cnt_5), 1);

      // Ejector stalls during the first coin.
      eject_ready = 1'b0;
      d0 = done_cnt;
      do_start(7);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("stall_denom", int'(coin_denom), 4'b0100);
         chk("stall_no_pulse", int'(coin_eject), 0);
      end
      eject_ready = 1'b1;
      @(negedge clk);
      chk("stall_release_pulse", int'(coin_eject), 1);
      wait_done(d0);
      @(negedge clk);
      chk("stall_cnt5", int'(cnt_5), 1);
      chk("stall_cnt2", int'(cnt_2), 1);

      // start re-pulsed while busy is ignored.
      d0 = done_cnt;
      do_start(12);
      repeat (3) @(negedge clk);
      change_in = 8'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(d0);
      repeat (3) @(negedge clk);
      chk("busy_start_total", int'(total_out), 12);
      chk("busy_start_busy", int'(busy), 0);

      // Reset in GAP after the first coin aborts the job.
      d0 = done_cnt;
      do_start(16);
      repeat (2) @(negedge clk);
      chk("abort_first_pulse", int'(coin_eject), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      coin_q.delete();
      res_q.delete();
      @(negedge clk);
      chk_all_zero("abort");
      rst = 1'b0;
      repeat (20) @(negedge clk);
      chk("abort_no_more_pulses", pulse_cyc.size(), 1);
      chk("abort_no_done", done_cnt, d0);

      // Random amounts with a randomly stalling ejector.
      rnd_ready = 1'b1;
      for (int i = 0; i < 25; i++) run_job($urandom_range(0, 255));
      @(posedge clk);
      rnd_ready = 1'b0;
      eject_ready = 1'b1;

      chk("coin_queue_empty", coin_q.size(), 0);
      chk("result_queue_empty", res_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
